// File: rtl/cla_arbiter.sv
// cla_arbiter: two-requester round-robin arbiter that time-shares one 32-bit
// carry-lookahead adder between two clients (e.g. PC increment and ALU add/sub).
// Each client presents add/subtract operations over a valid/ready handshake.
// The granted operation is computed in the same cycle and captured in a
// one-entry result register that is tagged with the winning requester's ID.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   reqN_valid_i/ready_o   requester N handshake (N = 0, 1)
//   reqN_a_i, reqN_b_i     requester N operands
//   reqN_sub_i             requester N: 1 = A-B, 0 = A+B
//   res_valid_o/ready_i    result handshake (one-entry output stage)
//   res_sum_o              registered sum/difference
//   res_cout_o             registered carry out (subtract: 1 = no borrow)
//   res_ovf_o              registered signed overflow
//   res_id_o               ID of the requester that produced the result
module cla_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_a_i,
  input  logic [31:0] req0_b_i,
  input  logic        req0_sub_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_a_i,
  input  logic [31:0] req1_b_i,
  input  logic        req1_sub_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [31:0] res_sum_o,
  output logic        res_cout_o,
  output logic        res_ovf_o,
  output logic        res_id_o
);

  // 32-bit carry-lookahead adder: 4-bit lookahead groups whose group
  // generate/propagate terms chain the carry between groups.
  // Returns {cout, sum}.
  function automatic logic [32:0] cla32(input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic        cin);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    logic [7:0]  gg;
    logic [7:0]  gp;
    g    = x & y;
    p    = x ^ y;
    c    = 33'd0;
    c[0] = cin;
    for (int k = 0; k < 8; k++) begin
      c[4*k+1] = g[4*k]   | (p[4*k]   & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      gg[k]    = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k]    = &p[4*k +: 4];
      c[4*k+4] = gg[k] | (gp[k] & c[4*k]);
    end
    return {c[32], p ^ c[31:0]};
  endfunction

  logic        full_q, full_d;
  logic        prio_q, prio_d;
  logic [31:0] sum_q, sum_d;
  logic        cout_q, cout_d;
  logic        ovf_q, ovf_d;
  logic        id_q, id_d;

  logic        can_accept_s;
  logic        gnt0_s, gnt1_s, gnt_any_s;
  logic [31:0] x_s, b_sel_s, y_s;
  logic        sub_sel_s;
  logic [32:0] add_s;
  logic        ovf_s;

  // Grant decision: the output stage can take a new result when empty or
  // being drained this cycle; contention is resolved by the priority pointer.
  always_comb begin
    can_accept_s = ~full_q | res_ready_i;
    gnt0_s       = 1'b0;
    gnt1_s       = 1'b0;
    if (rst_i || !can_accept_s) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (req0_valid_i && req1_valid_i) begin
      gnt0_s = ~prio_q;
      gnt1_s = prio_q;
    end else begin
      gnt0_s = req0_valid_i;
      gnt1_s = req1_valid_i;
    end
  end

  assign gnt_any_s    = gnt0_s | gnt1_s;
  assign req0_ready_o = gnt0_s;
  assign req1_ready_o = gnt1_s;

  // Shared adder operands. With no grant the mux defaults to requester 0;
  // the result is discarded in that case.
  always_comb begin
    if (gnt1_s) begin
      x_s       = req1_a_i;
      b_sel_s   = req1_b_i;
      sub_sel_s = req1_sub_i;
    end else begin
      x_s       = req0_a_i;
      b_sel_s   = req0_b_i;
      sub_sel_s = req0_sub_i;
    end
    // Subtract is A + ~B + 1, so the carry in is the subtract flag itself.
    y_s   = sub_sel_s ? ~b_sel_s : b_sel_s;
    add_s = cla32(x_s, y_s, sub_sel_s);
    ovf_s = (x_s[31] == y_s[31]) & (add_s[31] != x_s[31]);
  end

  // Result register and pointer next state. A grant loads a fresh result
  // (even while the old one drains); a drain without grant only clears full.
  always_comb begin
    full_d = full_q;
    prio_d = prio_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    id_d   = id_q;
    if (gnt_any_s) begin
      full_d = 1'b1;
      prio_d = ~gnt1_s;
      sum_d  = add_s[31:0];
      cout_d = add_s[32];
      ovf_d  = ovf_s;
      id_d   = gnt1_s;
    end else if (res_ready_i) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      prio_q <= RR_INIT;
      sum_q  <= 32'd0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      id_q   <= 1'b0;
    end else begin
      full_q <= full_d;
      prio_q <= prio_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      id_q   <= id_d;
    end
  end

  assign res_valid_o = full_q;
  assign res_sum_o   = sum_q;
  assign res_cout_o  = cout_q;
  assign res_ovf_o   = ovf_q;
  assign res_id_o    = id_q;

endmodule

// File: doc/cla_arbiter.md
# cla_arbiter

Two-requester, round-robin arbiter and sequencer that time-shares a single CLA_32 instance between two clients, such as the PC-increment path and the ALU add/sub path.
- Accepts one add or subtract operation per cycle over valid/ready handshakes.
- Drives the shared adder's operands and carry-in.
- Returns a registered result tagged with the requester's ID through a one-entry output stage with backpressure.

## Interface
- RR_INIT, default 0: requester that wins the first contended cycle after reset (0 or 1).
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  32  requester 0 operand A.
- req0_b  in  32  requester 0 operand B.
- req0_sub  in  1  requester 0: 1 = A−B, 0 = A+B.
- req1_valid, req1_ready, req1_a, req1_b, req1_sub: same as requester 0, for requester 1.
- res_valid  out  1  result register holds a valid result.
- res_ready  in  1  consumer takes the result this cycle.
- res_sum  out  32  registered sum/difference.
- res_cout  out  1  registered carry out; for subtract, 1 = no borrow.
- res_ovf  out  1  registered signed two's-complement overflow.
- res_id  out  1  ID of the requester that produced the result.

## Operation
- State: one-bit `full` (mirrors res_valid) and one-bit priority pointer `prio`.
- can_accept = !full | res_ready.
- Grant, combinational:
  - Only reqN_valid high and can_accept → grant N.
  - Both valid and can_accept → grant `prio`.
  - Neither valid, or !can_accept → no grant.
- reqN_ready = grant N. Both readies are forced 0 while rst is high.
- reqN_ready may depend on the other requester's valid. Requesters must not make valid depend on ready.
- A requester holding valid must keep a/b/sub stable until accepted.
- Pointer update:
  - On any grant, prio ← ~granted ID, so the loser of a contended cycle wins the next one.
  - No grant → prio holds.
- Shared adder, driven from the granted requester's payload (don't-care when no grant):
  - X = a.
  - Y = sub ? ~b : b.
  - Cin = sub.
- Overflow = (X[31] == Y[31]) & (S[31] != X[31]).
- On grant: res_sum ← S, res_cout ← Cout, res_ovf ← overflow, res_id ← granted ID, full ← 1.
- On res_valid & res_ready with no new grant: full ← 0. The result fields hold their last values.
- Simultaneous drain and grant: the new result replaces the old one in the same edge, and full stays 1.
- Backpressure: while full & !res_ready, both readies are 0 and the result fields are held stable.

## Timing
- Reset values: res_valid = 0, res_sum = 0, res_cout = 0, res_ovf = 0, res_id = 0, prio = RR_INIT.
- Reset mid-operation discards any held result. Requests active during the rst cycle are not accepted.
- Latency: accept in cycle N → res_valid high in cycle N+1.
- Throughput: one result per cycle while res_ready is held high.
- Starvation bound: a continuously valid requester is accepted within 2 accepting cycles.
- Adder path: request mux → CLA_32 → result register, all in one cycle. There is no output-side combinational path from res_ready to res_valid.
- res_ready → reqN_ready is combinational; this is the only ready-to-ready path.

## Test plan
- Reset, then only req0: a=0x0000_0005, b=0x0000_0003, sub=0 → req0_ready=1 in the same cycle; next cycle res_valid=1, res_sum=0x0000_0008, res_cout=0, res_ovf=0, res_id=0.
- Subtract and overflow on req1:
  - a=0x0000_0003, b=0x0000_0005, sub=1 → res_sum=0xFFFF_FFFE, res_cout=0 (borrow).
  - a=0x7FFF_FFFF, b=0x0000_0001, sub=0 → res_sum=0x8000_0000, res_ovf=1.
  - a=0xFFFF_FFFF, b=0x0000_0001, sub=0 → res_sum=0, res_cout=1, res_ovf=0.
- Contention with RR_INIT=0, both valid for 4 cycles, res_ready=1 → grants alternate 0,1,0,1; res_id sequence is 0,1,0,1, one cycle delayed.
- Backpressure: result held with res_ready=0 for 3 cycles while both requesters are valid → both readies 0, and res_sum/res_id stay stable. Then raise res_ready → drain and a new grant happen in the same cycle, and res_valid stays 1.
- Reset mid-stream: assert rst while full and req0_valid=1 → next cycle res_valid=0, prio=RR_INIT, and no request is accepted during the reset cycle.
- Idle drain: a single result with res_ready=1 and no further requests → res_valid falls after one cycle, and res_sum keeps its last value.
